// File: rtl/pom_lock_manager_pkg.sv
// Shared definitions for the hardware lock manager: command/ack codes,
// field positions inside the 64-bit command and ack words, FSM state type.
package pom_lock_manager_pkg;

  localparam logic [7:0] CMD_LOCK_CODE   = 8'h04;
  localparam logic [7:0] CMD_UNLOCK_CODE = 8'h06;
  localparam logic [7:0] ACK_OK_CODE     = 8'h01;
  localparam logic [7:0] ACK_REJECT_CODE = 8'h00;

  localparam int CMD_TYPE_L   = 0;
  localparam int CMD_TYPE_H   = 7;
  localparam int LOCK_ID_L    = 8;
  localparam int LOCK_ID_H    = 15;
  localparam int LOCK_ID_BITS = LOCK_ID_H - LOCK_ID_L + 1;

  localparam int ACK_CODE_L   = 0;
  localparam int ACK_CODE_H   = 7;
  localparam int ACK_LOCKID_L = 8;
  localparam int ACK_LOCKID_H = 15;

  typedef enum logic [1:0] {IDLE, EXEC, ACK} LockFsm_t;

endpackage

// File: rtl/pom_lock_manager_if.sv
// Command stream in / ack stream out of the lock manager.
//   cmd_in_*  : command word, valid/ready handshake, requester id
//   ack_out_* : ack word, valid/ready handshake, destination id
// master = command source / ack sink, slave = lock manager.
interface pom_lock_manager_if #(
  parameter int ACC_ID_BITS = 8
);
  logic [63:0]            cmd_in_tdata;
  logic                   cmd_in_tvalid;
  logic                   cmd_in_tready;
  logic [ACC_ID_BITS-1:0] cmd_in_tid;

  logic [63:0]            ack_out_tdata;
  logic                   ack_out_tvalid;
  logic                   ack_out_tready;
  logic [ACC_ID_BITS-1:0] ack_out_tdest;

  modport master (
    output cmd_in_tdata, cmd_in_tvalid, cmd_in_tid, ack_out_tready,
    input  cmd_in_tready, ack_out_tdata, ack_out_tvalid, ack_out_tdest
  );

  modport slave (
    input  cmd_in_tdata, cmd_in_tvalid, cmd_in_tid, ack_out_tready,
    output cmd_in_tready, ack_out_tdata, ack_out_tvalid, ack_out_tdest
  );
endinterface

// File: rtl/pom_lock_manager_table.sv
// Per-lock ownership table: busy bit and owner id for each lock.
// Combinational lookup of one lock id, single write port (acquire/release).
// Ports:
//   clk, rst          clock, async active-high reset
//   id, tid           lock id to look up / modify, requesting accelerator
//   acquire, release_op  one-cycle write strobes (mutually exclusive)
//   hit_free          looked-up lock is free
//   owner_match       looked-up lock is busy and owned by tid
//   id_in_range       id < NUM_LOCKS
//   busy              busy vector, bit i = lock i owned
module pom_lock_manager_table
  import pom_lock_manager_pkg::*;
#(
  parameter int NUM_LOCKS   = 16,
  parameter int ACC_ID_BITS = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [LOCK_ID_BITS-1:0] id,
  input  logic [ACC_ID_BITS-1:0]  tid,
  input  logic                    acquire,
  input  logic                    release_op,
  output logic                    hit_free,
  output logic                    owner_match,
  output logic                    id_in_range,
  output logic [NUM_LOCKS-1:0]    busy
);

  logic [NUM_LOCKS-1:0]   busy_q;
  logic [ACC_ID_BITS-1:0] owner_q [NUM_LOCKS];

  assign busy        = busy_q;
  // Full-width compare: ids beyond the pool never alias onto a real lock.
  assign id_in_range = (int'(id) < NUM_LOCKS);

  always_comb begin
    hit_free    = 1'b0;
    owner_match = 1'b0;
    for (int i = 0; i < NUM_LOCKS; i++) begin
      if (id == LOCK_ID_BITS'(i)) begin
        hit_free    = !busy_q[i];
        owner_match = busy_q[i] && (owner_q[i] == tid);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
      for (int i = 0; i < NUM_LOCKS; i++) owner_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_LOCKS; i++) begin
        if (id == LOCK_ID_BITS'(i)) begin
          if (acquire) begin
            busy_q[i]  <= 1'b1;
            owner_q[i] <= tid;
          end else if (release_op) begin
            busy_q[i] <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: rtl/pom_lock_manager.sv
// Hardware mutex pool: accepts lock/unlock commands, tracks ownership and
// returns OK/REJECT acks for lock commands to the requesting accelerator.
// Ports:
//   clk, rst        clock, async active-high reset
//   bus             command in / ack out streams (slave side)
//   lock_busy       bit i set while lock i is owned
//   grant_cnt       saturating count of OK acks
//   reject_cnt      saturating count of REJECT acks
//   err_sticky      set on bad unlock, out-of-range lock, unknown code
//   err_clr         pulse to clear err_sticky (a same-cycle error wins)
//
// state | meaning
// IDLE  | ready for a command
// EXEC  | one cycle: table lookup/update, build ack or finish unlock
// ACK   | ack held valid until the downstream takes it
module pom_lock_manager
  import pom_lock_manager_pkg::*;
#(
  parameter int NUM_LOCKS   = 16,
  parameter int ACC_ID_BITS = 8,
  parameter int CNT_BITS    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  pom_lock_manager_if.slave    bus,
  output logic [NUM_LOCKS-1:0] lock_busy,
  output logic [CNT_BITS-1:0]  grant_cnt,
  output logic [CNT_BITS-1:0]  reject_cnt,
  output logic                 err_sticky,
  input  logic                 err_clr
);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_EXEC = EXEC;
  localparam logic [1:0] ST_ACK  = ACK;

  logic [1:0]              state;
  logic                    rdy_q;
  logic [7:0]              code_q;
  logic [LOCK_ID_BITS-1:0] id_q;
  logic [ACC_ID_BITS-1:0]  tid_q;
  logic                    ack_vld;
  logic [63:0]             ack_data;
  logic [ACC_ID_BITS-1:0]  ack_dest;

  logic hit_free, owner_match, id_in_range;
  logic accept, in_exec, is_lock, is_unlock;
  logic grant_ok, unlock_ok, err_set;

  // Upper command bits carry no meaning for this block.
  logic unused_cmd_bits;
  assign unused_cmd_bits = ^bus.cmd_in_tdata[63:LOCK_ID_H+1];

  assign bus.cmd_in_tready  = rdy_q;
  assign bus.ack_out_tvalid = ack_vld;
  assign bus.ack_out_tdata  = ack_data;
  assign bus.ack_out_tdest  = ack_dest;

  assign accept    = rdy_q && bus.cmd_in_tvalid;
  assign in_exec   = (state == ST_EXEC);
  assign is_lock   = (code_q == CMD_LOCK_CODE);
  assign is_unlock = (code_q == CMD_UNLOCK_CODE);
  assign grant_ok  = in_exec && is_lock && id_in_range && hit_free;
  assign unlock_ok = in_exec && is_unlock && id_in_range && owner_match;
  assign err_set   = in_exec && ((is_lock && !id_in_range) ||
                                 (is_unlock && !(id_in_range && owner_match)) ||
                                 (!is_lock && !is_unlock));

  pom_lock_manager_table #(
    .NUM_LOCKS  (NUM_LOCKS),
    .ACC_ID_BITS(ACC_ID_BITS)
  ) u_table (
    .clk        (clk),
    .rst        (rst),
    .id         (id_q),
    .tid        (tid_q),
    .acquire    (grant_ok),
    .release_op (unlock_ok),
    .hit_free   (hit_free),
    .owner_match(owner_match),
    .id_in_range(id_in_range),
    .busy       (lock_busy)
  );

  // rdy_q is a flop rather than a decode of state so that it stays low
  // throughout reset and rises on the first edge after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      rdy_q      <= 1'b0;
      code_q     <= '0;
      id_q       <= '0;
      tid_q      <= '0;
      ack_vld    <= 1'b0;
      ack_data   <= '0;
      ack_dest   <= '0;
      grant_cnt  <= '0;
      reject_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            code_q <= bus.cmd_in_tdata[CMD_TYPE_H:CMD_TYPE_L];
            id_q   <= bus.cmd_in_tdata[LOCK_ID_H:LOCK_ID_L];
            tid_q  <= bus.cmd_in_tid;
            rdy_q  <= 1'b0;
            state  <= ST_EXEC;
          end else begin
            rdy_q <= 1'b1;
          end
        end
        ST_EXEC: begin
          if (is_lock) begin
            ack_vld  <= 1'b1;
            ack_dest <= tid_q;
            ack_data[ACK_CODE_H:ACK_CODE_L]     <= grant_ok ? ACK_OK_CODE : ACK_REJECT_CODE;
            ack_data[ACK_LOCKID_H:ACK_LOCKID_L] <= id_q;
            if (grant_ok) begin
              if (grant_cnt != '1) grant_cnt <= grant_cnt + CNT_BITS'(1);
            end else begin
              if (reject_cnt != '1) reject_cnt <= reject_cnt + CNT_BITS'(1);
            end
            state <= ST_ACK;
          end else begin
            rdy_q <= 1'b1;
            state <= ST_IDLE;
          end
        end
        ST_ACK: begin
          if (bus.ack_out_tready) begin
            ack_vld <= 1'b0;
            rdy_q   <= 1'b1;
            state   <= ST_IDLE;
          end
        end
        default: begin
          rdy_q <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          err_sticky <= 1'b0;
    else if (err_set) err_sticky <= 1'b1;
    else if (err_clr) err_sticky <= 1'b0;
  end

endmodule

// File: tb/tb_pom_lock_manager.sv
module tb_pom_lock_manager;
  import pom_lock_manager_pkg::*;

  localparam int NL = 16;
  localparam int AB = 8;
  localparam int CB = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic err_clr = 1'b0;
  logic [NL-1:0] lock_busy;
  logic [CB-1:0] grant_cnt, reject_cnt;
  logic err_sticky;

  always #5 clk = ~clk;

  pom_lock_manager_if #(.ACC_ID_BITS(AB)) bus ();

  pom_lock_manager #(.NUM_LOCKS(NL), .ACC_ID_BITS(AB), .CNT_BITS(CB)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .lock_busy (lock_busy),
    .grant_cnt (grant_cnt),
    .reject_cnt(reject_cnt),
    .err_sticky(err_sticky),
    .err_clr   (err_clr)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: lock table as plain arrays, counters as integers.
  bit         busy_m  [0:NL-1];
  logic [7:0] owner_m [0:NL-1];
  int         g_m, r_m;
  bit         err_m;

  typedef struct {
    logic [7:0]  code;
    logic [7:0]  id;
    logic [7:0]  tid;
    bit          pre_clr;
    bit          clr;
    bit          ack;
    logic [7:0]  ack_code;
    logic [15:0] busy;
    int          g;
    int          r;
    bit          err;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic [NL-1:0] model_busy();
    logic [NL-1:0] v;
    for (int i = 0; i < NL; i++) v[i] = busy_m[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NL; i++) begin busy_m[i] = 0; owner_m[i] = '0; end
    g_m = 0; r_m = 0; err_m = 0;
  endtask

  task automatic model_cmd(input logic [7:0] code, input logic [7:0] id, input logic [7:0] tid,
                           input bit clr, output bit ack, output logic [7:0] ack_code);
    int idx;
    bit e;
    idx = int'(id);
    e = 0; ack = 0; ack_code = ACK_REJECT_CODE;
    if (code == CMD_LOCK_CODE) begin
      ack = 1;
      if (idx < NL && !busy_m[idx]) begin
        busy_m[idx] = 1; owner_m[idx] = tid; ack_code = ACK_OK_CODE; g_m++;
      end else begin
        r_m++;
        if (idx >= NL) e = 1;
      end
    end else if (code == CMD_UNLOCK_CODE) begin
      if (idx < NL && busy_m[idx] && owner_m[idx] == tid) busy_m[idx] = 0;
      else e = 1;
    end else begin
      e = 1;
    end
    err_m = e ? 1'b1 : (clr ? 1'b0 : err_m);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.cmd_in_tvalid = 1'b0;
    @(negedge clk);
    chk("rst_cmd_tready", bus.cmd_in_tready, 0);
    chk("rst_ack_tvalid", bus.ack_out_tvalid, 0);
    chk("rst_ack_tdata", bus.ack_out_tdata, 0);
    chk("rst_ack_tdest", bus.ack_out_tdest, 0);
    chk("rst_lock_busy", lock_busy, 0);
    chk("rst_grant_cnt", grant_cnt, 0);
    chk("rst_reject_cnt", reject_cnt, 0);
    chk("rst_err", err_sticky, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", bus.cmd_in_tready, 1);
    model_reset();
  endtask

  // Returns #1 after the accepting edge (DUT now in EXEC).
  task automatic send_cmd(input logic [7:0] code, input logic [7:0] id, input logic [7:0] tid);
    int n;
    @(negedge clk);
    bus.cmd_in_tdata  = {$urandom(), 16'($urandom()), id, code};
    bus.cmd_in_tid    = tid;
    bus.cmd_in_tvalid = 1'b1;
    n = 0;
    while (!bus.cmd_in_tready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("cmd_accept_timeout", bus.cmd_in_tready, 1);
    @(posedge clk);
    #1;
    bus.cmd_in_tvalid = 1'b0;
    bus.cmd_in_tdata  = {$urandom(), $urandom()};
  endtask

  task automatic run_cmd(input logic [7:0] code, input logic [7:0] id, input logic [7:0] tid,
                         input bit clr, input bit exp_ack, input logic [7:0] exp_code,
                         input logic [NL-1:0] exp_busy, input int exp_g, input int exp_r,
                         input bit exp_err);
    send_cmd(code, id, tid);
    err_clr = clr;
    @(negedge clk);
    @(negedge clk);
    err_clr = 1'b0;
    chk("ack_tvalid", bus.ack_out_tvalid, exp_ack);
    if (exp_ack) begin
      chk("ack_tdata", bus.ack_out_tdata, {48'h0, id, exp_code});
      chk("ack_tdest", bus.ack_out_tdest, tid);
    end
    chk("lock_busy", lock_busy, exp_busy);
    chk("grant_cnt", grant_cnt, exp_g);
    chk("reject_cnt", reject_cnt, exp_r);
    chk("err_sticky", err_sticky, exp_err);
    if (exp_ack) begin
      @(negedge clk);
      chk("ack_drop", bus.ack_out_tvalid, 0);
      chk("ready_after_ack", bus.cmd_in_tready, 1);
    end
  endtask

  task automatic run_model(input logic [7:0] code, input logic [7:0] id, input logic [7:0] tid,
                           input bit clr);
    bit a;
    logic [7:0] c;
    model_cmd(code, id, tid, clr, a, c);
    run_cmd(code, id, tid, clr, a, c, model_busy(), g_m, r_m, err_m);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("err_clr", err_sticky, 0);
    err_m = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cmd_in_tdata   = '0;
    bus.cmd_in_tvalid  = 1'b0;
    bus.cmd_in_tid     = '0;
    bus.ack_out_tready = 1'b1;

    //            code             id     tid    pre clr ack code             busy     g  r  err
    tbl[0]  = '{CMD_LOCK_CODE,   8'd3,  8'd5,  0, 0, 1, ACK_OK_CODE,     16'h0008, 1, 0, 0};
    tbl[1]  = '{CMD_LOCK_CODE,   8'd3,  8'd7,  0, 0, 1, ACK_REJECT_CODE, 16'h0008, 1, 1, 0};
    tbl[2]  = '{CMD_UNLOCK_CODE, 8'd3,  8'd7,  0, 0, 0, ACK_REJECT_CODE, 16'h0008, 1, 1, 1};
    tbl[3]  = '{CMD_UNLOCK_CODE, 8'd3,  8'd5,  0, 0, 0, ACK_REJECT_CODE, 16'h0000, 1, 1, 1};
    tbl[4]  = '{CMD_LOCK_CODE,   8'd3,  8'd7,  0, 0, 1, ACK_OK_CODE,     16'h0008, 2, 1, 1};
    tbl[5]  = '{CMD_LOCK_CODE,   8'd20, 8'd9,  0, 0, 1, ACK_REJECT_CODE, 16'h0008, 2, 2, 1};
    tbl[6]  = '{CMD_UNLOCK_CODE, 8'd3,  8'd7,  1, 1, 0, ACK_REJECT_CODE, 16'h0000, 2, 2, 0};
    tbl[7]  = '{8'h55,           8'd1,  8'd2,  0, 1, 0, ACK_REJECT_CODE, 16'h0000, 2, 2, 1};
    tbl[8]  = '{CMD_LOCK_CODE,   8'd15, 8'd1,  0, 0, 1, ACK_OK_CODE,     16'h8000, 3, 2, 1};
    tbl[9]  = '{CMD_UNLOCK_CODE, 8'd16, 8'd1,  1, 0, 0, ACK_REJECT_CODE, 16'h8000, 3, 2, 1};
    tbl[10] = '{CMD_LOCK_CODE,   8'd0,  8'd255,0, 0, 1, ACK_OK_CODE,     16'h8001, 4, 2, 1};
    tbl[11] = '{CMD_LOCK_CODE,   8'd0,  8'd255,0, 0, 1, ACK_REJECT_CODE, 16'h8001, 4, 3, 1};
    tbl[12] = '{CMD_LOCK_CODE,   8'h13, 8'd4,  1, 0, 1, ACK_REJECT_CODE, 16'h8001, 4, 4, 1};

    // Reset state is checked while rst is still asserted from time 0.
    repeat (2) @(negedge clk);
    chk("init_cmd_tready", bus.cmd_in_tready, 0);
    chk("init_ack_tvalid", bus.ack_out_tvalid, 0);
    chk("init_lock_busy", lock_busy, 0);
    do_reset();

    for (int i = 0; i < 13; i++) begin
      if (tbl[i].pre_clr) pulse_clr();
      run_cmd(tbl[i].code, tbl[i].id, tbl[i].tid, tbl[i].clr, tbl[i].ack, tbl[i].ack_code,
              tbl[i].busy, tbl[i].g, tbl[i].r, tbl[i].err);
    end

    // Downstream stall: ack held for 10 cycles, no new command accepted.
    bus.ack_out_tready = 1'b0;
    send_cmd(CMD_LOCK_CODE, 8'd5, 8'd3);
    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      chk("stall_tvalid", bus.ack_out_tvalid, 1);
      chk("stall_tdata", bus.ack_out_tdata, {48'h0, 8'd5, ACK_OK_CODE});
      chk("stall_tdest", bus.ack_out_tdest, 3);
      chk("stall_cmd_tready", bus.cmd_in_tready, 0);
      @(negedge clk);
    end
    bus.ack_out_tready = 1'b1;
    @(negedge clk);
    chk("stall_release_tvalid", bus.ack_out_tvalid, 0);
    chk("stall_release_ready", bus.cmd_in_tready, 1);
    run_cmd(CMD_LOCK_CODE, 8'd6, 8'd2, 0, 1, ACK_OK_CODE, 16'h8061, 6, 4, 1);

    // Fill every lock, then reset while the last ack is pending.
    do_reset();
    for (int i = 0; i < NL - 1; i++) run_model(CMD_LOCK_CODE, 8'(i), 8'(i), 0);
    bus.ack_out_tready = 1'b0;
    send_cmd(CMD_LOCK_CODE, 8'd15, 8'd15);
    @(negedge clk);
    @(negedge clk);
    chk("pre_reset_ack", bus.ack_out_tvalid, 1);
    chk("pre_reset_busy", lock_busy, 16'hFFFF);
    rst = 1'b1;
    #1;
    chk("midrst_tvalid", bus.ack_out_tvalid, 0);
    chk("midrst_busy", lock_busy, 0);
    chk("midrst_grant", grant_cnt, 0);
    chk("midrst_reject", reject_cnt, 0);
    chk("midrst_cmd_tready", bus.cmd_in_tready, 0);
    @(negedge clk);
    rst = 1'b0;
    bus.ack_out_tready = 1'b1;
    model_reset();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("no_stale_ack", bus.ack_out_tvalid, 0);
    end
    run_model(CMD_LOCK_CODE, 8'd0, 8'd1, 0);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 300; n++) begin
      int sel;
      logic [7:0] code;
      sel = $urandom_range(0, 9);
      if (sel < 5)      code = CMD_LOCK_CODE;
      else if (sel < 9) code = CMD_UNLOCK_CODE;
      else              code = 8'h07;
      run_model(code, 8'($urandom_range(0, 19)), 8'($urandom_range(0, 3)),
                ($urandom_range(0, 7) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
